// File: rtl/nv_fifo_ctrl_pkg.sv
// Shared sizes, types and pointer helper for the nv_fifo_ctrl_80x18 sequencer.
package nv_fifo_ctrl_pkg;

   localparam int unsigned FIFO_DEPTH = 80;
   localparam int unsigned FIFO_WIDTH = 18;
   localparam int unsigned FIFO_AW    = 7;

   typedef logic [FIFO_AW-1:0]    ptr_t;
   typedef logic [FIFO_AW-1:0]    cnt_t;
   typedef logic [FIFO_WIDTH-1:0] data_t;

   // Advance a RAM pointer, wrapping DEPTH-1 -> 0 (depth is not a power of two).
   function automatic ptr_t wrap_inc(input ptr_t p);
      return (p == ptr_t'(FIFO_DEPTH - 1)) ? ptr_t'(0) : ptr_t'(p + ptr_t'(1));
   endfunction

endpackage

// File: rtl/nv_fifo_wrap_ptr.sv
// Mod-DEPTH pointer: advances by one on i_inc, clears on synchronous reset.
module nv_fifo_wrap_ptr
   import nv_fifo_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_inc,
   output ptr_t o_ptr
);

   ptr_t r_ptr;

   // Pointer register with wrap at DEPTH-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= wrap_inc(r_ptr);
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/nv_fifo_ctrl_80x18.sv
// Valid/ready FIFO sequencer driving an external 80x18 two-port RAM with
// registered read address, output register and bypass mux.
module nv_fifo_ctrl_80x18
   import nv_fifo_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_pvld,
   output logic                  wr_prdy,
   input  logic [FIFO_WIDTH-1:0] wr_pd,
   output logic                  rd_pvld,
   input  logic                  rd_prdy,
   output logic [FIFO_AW-1:0]    ram_wa,
   output logic                  ram_we,
   output logic [FIFO_WIDTH-1:0] ram_di,
   output logic [FIFO_AW-1:0]    ram_ra,
   output logic                  ram_re,
   output logic                  ram_ore,
   output logic                  ram_byp_sel,
   output logic [FIFO_WIDTH-1:0] ram_dbyp,
   output logic [FIFO_WIDTH-1:0] rd_pd,
   output logic [FIFO_AW-1:0]    ram_cnt
);

   cnt_t r_ram_cnt;
   logic r_s1_vld;
   logic r_s2_vld;

   ptr_t w_wp;
   ptr_t w_rp;
   logic w_prdy;
   logic w_push;
   logic w_adv2;
   logic w_cnt_zero;
   logic w_rd_pend;
   logic w_bypass;
   logic w_write;
   logic w_capture;
   logic w_issue;

   // Accept while RAM has a free slot; a slot frees only when its data is captured.
   assign w_prdy     = !rst & (r_ram_cnt < cnt_t'(FIFO_DEPTH));
   assign w_push     = wr_pvld & w_prdy;
   assign w_adv2     = !r_s2_vld | rd_prdy;
   assign w_cnt_zero = (r_ram_cnt == cnt_t'(0));
   // Entries written but not yet issued: the one held in ra_d is excluded.
   assign w_rd_pend  = (r_ram_cnt > cnt_t'(r_s1_vld));

   // An empty FIFO with a free output register skips the RAM entirely.
   assign w_bypass  = w_push & w_cnt_zero & w_adv2;
   assign w_write   = w_push & !w_bypass;
   assign w_capture = !rst & r_s1_vld & w_adv2 & !w_bypass;
   assign w_issue   = !rst & w_rd_pend & (!r_s1_vld | w_capture);

   // Write and read pointers into the RAM.
   nv_fifo_wrap_ptr u_wp (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_write),
      .o_ptr (w_wp)
   );

   nv_fifo_wrap_ptr u_rp (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_issue),
      .o_ptr (w_rp)
   );

   // Occupancy and read-pipeline stage valids.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ram_cnt <= '0;
         r_s1_vld  <= 1'b0;
         r_s2_vld  <= 1'b0;
      end else begin
         case ({w_write, w_capture})
            2'b10:   r_ram_cnt <= r_ram_cnt + cnt_t'(1);
            2'b01:   r_ram_cnt <= r_ram_cnt - cnt_t'(1);
            default: r_ram_cnt <= r_ram_cnt;
         endcase
         r_s1_vld <= w_issue | (r_s1_vld & !w_capture);
         r_s2_vld <= w_bypass | w_capture | (r_s2_vld & !rd_prdy);
      end
   end

   assign wr_prdy     = w_prdy;
   assign rd_pvld     = r_s2_vld;
   assign ram_wa      = w_wp;
   assign ram_we      = w_write;
   assign ram_di      = wr_pd;
   assign ram_ra      = w_rp;
   assign ram_re      = w_issue;
   assign ram_ore     = w_bypass | w_capture;
   assign ram_byp_sel = w_bypass;
   assign ram_dbyp    = wr_pd;
   assign ram_cnt     = r_ram_cnt;
   // Read data comes from the RAM dout at the parent; this port is tied off.
   assign rd_pd       = '0;

   a_cnt_range : assert property (@(posedge clk) disable iff (rst)
      r_ram_cnt <= cnt_t'(FIFO_DEPTH));
   a_write_room : assert property (@(posedge clk) disable iff (rst)
      w_write |-> (r_ram_cnt < cnt_t'(FIFO_DEPTH)));
   a_capture_s1 : assert property (@(posedge clk) disable iff (rst)
      w_capture |-> r_s1_vld);
   a_byp_excl : assert property (@(posedge clk) disable iff (rst)
      !(w_bypass & w_capture));

endmodule

// File: tb/tb_nv_fifo_ctrl_80x18.sv
// Directed bench for nv_fifo_ctrl_80x18 with a behavioural model of the external RAM.
module tb_nv_fifo_ctrl_80x18;

   localparam int unsigned DEPTH = 80;
   localparam int unsigned WIDTH = 18;
   localparam int unsigned AW    = 7;

   logic             clk = 1'b0;
   logic             rst;
   logic             wr_pvld;
   logic             wr_prdy;
   logic [WIDTH-1:0] wr_pd;
   logic             rd_pvld;
   logic             rd_prdy;
   logic [AW-1:0]    ram_wa;
   logic             ram_we;
   logic [WIDTH-1:0] ram_di;
   logic [AW-1:0]    ram_ra;
   logic             ram_re;
   logic             ram_ore;
   logic             ram_byp_sel;
   logic [WIDTH-1:0] ram_dbyp;
   logic [WIDTH-1:0] dut_rd_pd;
   logic [AW-1:0]    ram_cnt;

   always #5 clk = ~clk;

   nv_fifo_ctrl_80x18 dut (
      .clk         (clk),
      .rst         (rst),
      .wr_pvld     (wr_pvld),
      .wr_prdy     (wr_prdy),
      .wr_pd       (wr_pd),
      .rd_pvld     (rd_pvld),
      .rd_prdy     (rd_prdy),
      .ram_wa      (ram_wa),
      .ram_we      (ram_we),
      .ram_di      (ram_di),
      .ram_ra      (ram_ra),
      .ram_re      (ram_re),
      .ram_ore     (ram_ore),
      .ram_byp_sel (ram_byp_sel),
      .ram_dbyp    (ram_dbyp),
      .rd_pd       (dut_rd_pd),
      .ram_cnt     (ram_cnt)
   );

   // External RAM: write port, registered read address, output register with bypass.
   logic [WIDTH-1:0] mem [0:DEPTH-1];
   logic [AW-1:0]    ra_d;
   logic [WIDTH-1:0] dout;

   always @(posedge clk) begin
      if (ram_we) mem[ram_wa] <= ram_di;
      if (ram_re) ra_d <= ram_ra;
      if (ram_ore) dout <= ram_byp_sel ? ram_dbyp : mem[ra_d];
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: order of accepted words, and output stability while stalled.
   logic [WIDTH-1:0] sb_q [$];
   logic [WIDTH-1:0] sb_exp;
   logic             hold_vld = 1'b0;
   logic [WIDTH-1:0] hold_pd;

   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         hold_vld = 1'b0;
      end else begin
         if (hold_vld) begin
            check_val("hold_pvld", rd_pvld, 1);
            check_val("hold_data", dout, hold_pd);
         end
         if (rd_pvld && rd_prdy) begin
            check_val("sb_nonempty", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
               sb_exp = sb_q.pop_front();
               check_val("sb_data", dout, sb_exp);
            end
         end
         if (wr_pvld && wr_prdy) sb_q.push_back(wr_pd);
         hold_vld = rd_pvld & !rd_prdy;
         hold_pd  = dout;
      end
   end

   task automatic drain(input string tag);
      rd_prdy = 1'b1;
      wr_pvld = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (!rd_pvld && sb_q.size() == 0 && ram_cnt == 0) break;
         tick();
      end
      @(negedge clk);
      check_val({tag, "_q"}, sb_q.size(), 0);
      check_val({tag, "_pvld"}, rd_pvld, 0);
      check_val({tag, "_cnt"}, ram_cnt, 0);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
      repeat (3) tick();
      @(negedge clk);
      check_val("rst_prdy", wr_prdy, 0);
      check_val("rst_en", {ram_we, ram_re, ram_ore}, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_val("post_rst_prdy", wr_prdy, 1);
      check_val("post_rst_pvld", rd_pvld, 0);
      check_val("post_rst_cnt", ram_cnt, 0);

      // Bypass of a single word into the empty FIFO.
      tick();
      rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = 18'h000AB;
      @(negedge clk);
      check_val("t1_byp", ram_byp_sel, 1);
      check_val("t1_ore", ram_ore, 1);
      check_val("t1_we0", ram_we, 0);
      tick();
      wr_pvld = 1'b0;
      @(negedge clk);
      check_val("t1_pvld", rd_pvld, 1);
      check_val("t1_data", dout, 32'h000AB);
      check_val("t1_we1", ram_we, 0);
      tick();
      @(negedge clk);
      check_val("t1_empty", rd_pvld, 0);

      // Fill with a stalled consumer: 1 word in the output register + 80 in RAM.
      tick();
      rd_prdy = 1'b0;
      for (int i = 0; i < 81; i++) begin
         wr_pvld = 1'b1;
         wr_pd   = 18'(i);
         @(negedge clk);
         check_val("t2_prdy", wr_prdy, 1);
         tick();
      end
      wr_pd = 18'h3FFFF;
      @(negedge clk);
      check_val("t2_full_prdy", wr_prdy, 0);
      check_val("t2_full_cnt", ram_cnt, 80);
      check_val("t2_wa_wrap", ram_wa, 0);
      check_val("t2_ra", ram_ra, 1);
      check_val("t2_pvld", rd_pvld, 1);
      check_val("t2_head", dout, 0);

      // Full, both sides streaming: one word per cycle, count pinned at 79..80.
      tick();
      rd_prdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         wr_pvld = 1'b1;
         wr_pd   = 18'(100 + i);
         @(negedge clk);
         check_val("t3_pop", rd_pvld & rd_prdy, 1);
         check_val("t3_cnt", (ram_cnt == 79 || ram_cnt == 80), 1);
         if (i > 0) check_val("t3_push", wr_prdy, 1);
         tick();
      end
      drain("t3_drain");
      @(negedge clk);
      check_val("t3_wp", ram_wa, 39);
      check_val("t3_rp", ram_ra, 39);
      tick();

      // Toggling consumer, random producer.
      for (int i = 0; i < 200; i++) begin
         rd_prdy = (i % 2 == 0);
         wr_pvld = 1'($urandom_range(0, 1));
         wr_pd   = 18'($urandom);
         tick();
      end
      drain("t4_drain");

      // Single push into a non-empty FIFO takes the 3-cycle RAM path.
      rd_prdy = 1'b0; wr_pvld = 1'b1; wr_pd = 18'h00111;
      @(negedge clk);
      check_val("t6_byp_a", ram_byp_sel, 1);
      tick();
      wr_pd = 18'h00222;
      @(negedge clk);
      check_val("t6_we_b", ram_we, 1);
      tick();
      wr_pvld = 1'b0;
      @(negedge clk);
      check_val("t6_re_b", ram_re, 1);
      check_val("t6_cnt_b", ram_cnt, 1);
      tick();
      rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = 18'h00333;
      @(negedge clk);
      check_val("t6_t0_we", ram_we, 1);
      check_val("t6_t0_cnt", ram_cnt, 1);
      check_val("t6_t0_re", ram_re, 0);
      check_val("t6_t0_ore", ram_ore, 1);
      tick();
      wr_pvld = 1'b0;
      @(negedge clk);
      check_val("t6_t1_re", ram_re, 1);
      check_val("t6_t1_ore", ram_ore, 0);
      check_val("t6_t1_data", dout, 32'h00222);
      tick();
      @(negedge clk);
      check_val("t6_t2_ore", ram_ore, 1);
      check_val("t6_t2_re", ram_re, 0);
      check_val("t6_t2_pvld", rd_pvld, 0);
      tick();
      @(negedge clk);
      check_val("t6_t3_pvld", rd_pvld, 1);
      check_val("t6_t3_data", dout, 32'h00333);
      tick();
      @(negedge clk);
      check_val("t6_t4_pvld", rd_pvld, 0);
      check_val("t6_t4_cnt", ram_cnt, 0);
      tick();

      // Reset while the pipeline holds data: 1 word out, 1 in ra_d, 37 in RAM.
      rd_prdy = 1'b0;
      for (int i = 0; i < 38; i++) begin
         wr_pvld = 1'b1;
         wr_pd   = 18'(18'h00200 + 18'(i));
         tick();
      end
      wr_pvld = 1'b0;
      @(negedge clk);
      check_val("t5_cnt", ram_cnt, 37);
      check_val("t5_pvld", rd_pvld, 1);
      tick();
      rst = 1'b1; rd_prdy = 1'b1;
      @(negedge clk);
      check_val("t5_rst_prdy", wr_prdy, 0);
      check_val("t5_rst_en", {ram_we, ram_re, ram_ore}, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_val("t5_pvld0", rd_pvld, 0);
      check_val("t5_cnt0", ram_cnt, 0);
      check_val("t5_prdy1", wr_prdy, 1);
      tick();
      wr_pvld = 1'b1; wr_pd = 18'h00BEE;
      @(negedge clk);
      check_val("t5_byp", ram_byp_sel, 1);
      check_val("t5_we", ram_we, 0);
      tick();
      wr_pvld = 1'b0;
      @(negedge clk);
      check_val("t5_out_pvld", rd_pvld, 1);
      check_val("t5_out_data", dout, 32'h00BEE);
      tick();
      drain("t5_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
